down_timer: RTL

- Loadable down-counter/timer: the counting-down counterpart of the team's up-counter with terminal-count MAX.
- Loads a start value and decrements on enabled cycles.
- Emits a combinational terminal-count strobe (tc) that can drive the next stage's enable in a cascade, plus a registered done pulse.
- Supports one-shot and auto-reload modes. Used as a cycle timer and as the underflow end of counter chains.

---
 rtl/timer_pkg.sv | 12 +
 rtl/timer_prescaler.sv | 33 +++
 rtl/down_timer.sv | 106 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the down_timer block: FSM state encoding and default width.
package timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for down_timer: wraps every PRESCALE enabled steps and flags the wrap cycle.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  output logic wrap
);

  // PRESCALE=1 still needs a 1-bit counter; it simply wraps every step.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  assign wrap = step && (ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (clear) begin
      ps_cnt <= '0;
    end else if (step) begin
      ps_cnt <= wrap ? '0 : ps_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes, combinational tc cascade
// output and registered done pulse. Define TIMER_PRESCALE_EN to add the PRESCALE divider.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             busy,
  output logic             zero
);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             done_next;
  logic             dec;
  logic             expire;

`ifdef TIMER_PRESCALE_EN
  logic ps_clear;
  assign ps_clear = clear | load | expire;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ps_clear),
    .step  ((state == ST_RUN) && en),
    .wrap  (dec)
  );
`else
  // PRESCALE is meaningless without the divider; consume it so the default build stays clean.
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign dec = (state == ST_RUN) && en;
`endif

  assign expire = dec && (count == WIDTH'(1));
  assign tc     = expire;
  assign busy   = (state == ST_RUN);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next  = state;
    count_next  = count;
    reload_next = reload_reg;
    done_next   = 1'b0;

    if (clear) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else if (load) begin
      count_next  = load_val;
      reload_next = load_val;
      if (load_val == '0) begin
        // A zero start expires immediately without ever passing through count==1.
        state_next = ST_EXPIRED;
        done_next  = 1'b1;
      end else begin
        state_next = ST_RUN;
      end
    end else if (dec) begin
      if (expire) begin
        done_next = 1'b1;
        if (auto_reload) begin
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = ST_EXPIRED;
        end
      end else begin
        count_next = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
      zero       <= 1'b1;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      done       <= done_next;
      zero       <= (count_next == '0);
    end
  end

endmodule
